exp_adder_8b: RTL and testbench

//   Biased-exponent adder for the FPU multiply path: adds two 8-bit biased

---
 rtl/exp_adder_8b_pkg.sv | 15 +
 rtl/exp_adder_8b_if.sv | 14 +
 rtl/exp_adder_8b_core.sv | 55 +++++
 rtl/exp_adder_8b.sv | 35 +++
 tb/tb_exp_adder_8b.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/exp_adder_8b_pkg.sv
// Shared FPU definitions: exponent width, exponent bias and the full-adder cell
// used by the exponent datapath.
package fpu_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam logic [7:0]  EXP_BIAS = 8'd128;

   typedef logic [EXP_W-1:0] exp_t;

   // Returns {carry_out, sum} of a single full-adder cell.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
      return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
   endfunction

endpackage

// File: rtl/exp_adder_8b_if.sv
// Exponent adder operand/result bundle; clock and reset stay as plain ports.
interface exp_adder_8b_if;
   import fpu_pkg::*;

   exp_t exp1;
   exp_t exp2;
   exp_t sum;
   logic ovf;
   logic unf;

   modport master (output exp1, output exp2, input sum, input ovf, input unf);
   modport slave  (input exp1, input exp2, output sum, output ovf, output unf);

endinterface

// File: rtl/exp_adder_8b_core.sv
// Combinational biased-exponent adder: 9-bit ripple-carry add, then a ripple
// subtract of the bias whose borrow and bit 8 give the underflow/overflow flags.
module exp_add_core
   import fpu_pkg::*;
(
   input  exp_t exp1,
   input  exp_t exp2,
   output exp_t sum_n,
   output logic ovf_n,
   output logic unf_n
);

   logic [8:0] a9;
   logic [8:0] b9;
   logic [8:0] nbias9;
   logic [8:0] t;
   logic [8:0] d;
   logic       add_c;
   logic       sub_c;
   logic [1:0] fa_add;
   logic [1:0] fa_sub;

   assign a9     = {1'b0, exp1};
   assign b9     = {1'b0, exp2};
   assign nbias9 = ~{1'b0, EXP_BIAS};

   always_comb begin
      add_c  = 1'b0;
      fa_add = '0;
      t      = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         fa_add = full_add(a9[i], b9[i], add_c);
         t[i]   = fa_add[0];
         add_c  = fa_add[1];
      end
   end

   // t - 128 as t + ~128 + 1; a missing carry-out is a borrow, i.e. t < 128.
   always_comb begin
      sub_c  = 1'b1;
      fa_sub = '0;
      d      = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         fa_sub = full_add(t[i], nbias9[i], sub_c);
         d[i]   = fa_sub[0];
         sub_c  = fa_sub[1];
      end
   end

   // Without a borrow, d >= 256 exactly when t > 383.
   assign sum_n = d[7:0];
   assign unf_n = ~sub_c;
   assign ovf_n = sub_c & d[8];

endmodule

// File: rtl/exp_adder_8b.sv
// Biased-exponent adder for the FPU multiply path: registered
// (exp1 + exp2 - bias) with underflow/overflow flags, one cycle of latency.
module exp_adder_8b
   import fpu_pkg::*;
(
   input  logic           CLK,
   input  logic           nRST,
   exp_adder_8b_if.slave  bus
);

   exp_t sum_n;
   logic ovf_n;
   logic unf_n;

   exp_add_core u_core (
      .exp1  (bus.exp1),
      .exp2  (bus.exp2),
      .sum_n (sum_n),
      .ovf_n (ovf_n),
      .unf_n (unf_n)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bus.sum <= '0;
         bus.ovf <= 1'b0;
         bus.unf <= 1'b0;
      end else begin
         bus.sum <= sum_n;
         bus.ovf <= ovf_n;
         bus.unf <= unf_n;
      end
   end

endmodule

// File: tb/tb_exp_adder_8b.sv
// Scoreboard bench for exp_adder_8b: directed corner cases, random pairs and an
// exhaustive sweep checked one cycle later against an integer reference model.
module tb_exp_adder_8b;
   import fpu_pkg::*;

   typedef struct packed {
      logic [7:0] e1;
      logic [7:0] e2;
      logic [7:0] sum;
      logic       ovf;
      logic       unf;
   } exp_rec_t;

   logic CLK = 1'b0;
   logic nRST;
   logic in_valid;
   logic pend;

   int errors = 0;
   int checks = 0;

   exp_rec_t sb[$];
   exp_rec_t mon_rec;

   exp_adder_8b_if bus ();

   exp_adder_8b dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_rec_t model(input int a, input int b);
      exp_rec_t m;
      int s;
      s     = a + b;
      m.e1  = 8'(a);
      m.e2  = 8'(b);
      m.sum = 8'((s - 128 + 256) % 256);
      m.ovf = (s > 383);
      m.unf = (s < 128);
      return m;
   endfunction

   task automatic issue_rec(input exp_rec_t r);
      @(posedge CLK);
      #1;
      bus.exp1 = r.e1;
      bus.exp2 = r.e2;
      in_valid = 1'b1;
      sb.push_back(r);
   endtask

   task automatic issue(input int a, input int b);
      issue_rec(model(a, b));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_sum"}, int'(bus.sum), 0);
      check({tag, "_ovf"}, int'(bus.ovf), 0);
      check({tag, "_unf"}, int'(bus.unf), 0);
   endtask

   // A result is due on the cycle after an operand pair was captured.
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) pend <= 1'b0;
      else       pend <= in_valid;
   end

   always @(negedge CLK) begin
      if (pend) begin
         if (sb.size() == 0) begin
            check("sb_underrun", 1, 0);
         end else begin
            mon_rec = sb.pop_front();
            check($sformatf("sum(%0d,%0d)", mon_rec.e1, mon_rec.e2), int'(bus.sum), int'(mon_rec.sum));
            check($sformatf("ovf(%0d,%0d)", mon_rec.e1, mon_rec.e2), int'(bus.ovf), int'(mon_rec.ovf));
            check($sformatf("unf(%0d,%0d)", mon_rec.e1, mon_rec.e2), int'(bus.unf), int'(mon_rec.unf));
         end
      end
   end

   exp_rec_t directed[$] = '{
      '{e1: 8'd130, e2: 8'd120, sum: 8'd122, ovf: 1'b0, unf: 1'b0},
      '{e1: 8'd100, e2: 8'd27,  sum: 8'd255, ovf: 1'b0, unf: 1'b1},
      '{e1: 8'd100, e2: 8'd28,  sum: 8'd0,   ovf: 1'b0, unf: 1'b0},
      '{e1: 8'd200, e2: 8'd183, sum: 8'd255, ovf: 1'b0, unf: 1'b0},
      '{e1: 8'd200, e2: 8'd184, sum: 8'd0,   ovf: 1'b1, unf: 1'b0},
      '{e1: 8'd0,   e2: 8'd0,   sum: 8'd128, ovf: 1'b0, unf: 1'b1},
      '{e1: 8'd255, e2: 8'd255, sum: 8'd126, ovf: 1'b1, unf: 1'b0}
   };

   initial begin
      nRST     = 1'b0;
      in_valid = 1'b0;
      bus.exp1 = 8'd200;
      bus.exp2 = 8'd200;
      repeat (3) @(posedge CLK);
      #1;
      check_cleared("reset");

      // Release away from the edge; the held (200,200) pair is the first result.
      @(negedge CLK);
      nRST     = 1'b1;
      #1;
      check_cleared("post_release");
      in_valid = 1'b1;
      sb.push_back('{e1: 8'd200, e2: 8'd200, sum: 8'h10, ovf: 1'b1, unf: 1'b0});

      foreach (directed[i]) issue_rec(directed[i]);

      for (int i = 0; i < 1000; i++)
         issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

      // Mid-stream reset: outputs clear at once and the in-flight pair is dropped.
      issue(255, 255);
      @(negedge CLK);
      issue(200, 200);
      #2;
      nRST = 1'b0;
      #1;
      check_cleared("midreset");
      sb.delete();
      in_valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_cleared("midreset_hold");
      @(negedge CLK);
      nRST = 1'b1;

      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 256; b++)
            issue(a, b);

      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("sb_drain", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
